// File: rtl/onehot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : onehot_pkg
// Description : Shared defaults, index-width helper and status-flag encodings
//               for the one-hot encoder pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package onehot_pkg;

    localparam int DEFAULT_N = 4;

    // A 1-bit index is kept even for degenerate widths so ports never collapse.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_ZERO  = 2'd1,
        ERR_MULTI = 2'd2
    } err_kind_e;

endpackage : onehot_pkg
`default_nettype wire

// File: rtl/onehot_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : onehot_prio_enc
// Description : Combinational LSB-priority encoder with any/multi flags.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_prio_enc
    import onehot_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any,
    output logic         multi
);

    logic [N-1:0] w_vec_dec;
    logic [N-1:0] w_rest;

    // Scanning from the top down lets the lowest set bit win.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_vec_dec = vec - N'(1);
    assign w_rest    = vec & w_vec_dec;
    assign any       = |vec;
    assign multi     = |w_rest;

endmodule : onehot_prio_enc
`default_nettype wire

// File: rtl/onehot_encoder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : onehot_encoder_pipe
// Description : Registered one-hot to binary encoder with legality check,
//               saturating error counter and valid/ready output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_encoder_pipe
    import onehot_pkg::*;
#(
    parameter int N    = DEFAULT_N,
    parameter int W    = idx_width(N),
    parameter int ERRW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_vec,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_idx,
    output logic            out_err,
    output logic            out_zero,
    input  logic            err_clr,
    output logic [ERRW-1:0] err_count
);

    localparam logic [ERRW-1:0] C_ERR_MAX = '1;

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic            w_accept;
    logic [N-1:0]    w_vec;
    logic [W-1:0]    w_idx;
    logic            w_any;
    logic            w_multi;
    logic            w_illegal;
    logic [W-1:0]    r_idx;
    logic            r_err;
    logic            r_zero;
    logic [ERRW-1:0] r_err_count;

    assign out_valid = (r_state == S_FULL);
    assign in_ready  = ~out_valid | out_ready;
    assign w_accept  = in_valid & in_ready;

    // Gating keeps an undriven in_vec out of every register when idle.
    assign w_vec     = w_accept ? in_vec : '0;
    assign w_illegal = w_accept & (~w_any | w_multi);

    onehot_prio_enc #(
        .N (N),
        .W (W)
    ) u_prio_enc (
        .vec   (w_vec),
        .idx   (w_idx),
        .any   (w_any),
        .multi (w_multi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: if (w_accept)  w_state_next = S_FULL;
            S_FULL:  if (out_ready) w_state_next = w_accept ? S_FULL : S_EMPTY;
            default: w_state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_err  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_idx  <= w_idx;
            r_err  <= ~w_any | w_multi;
            r_zero <= ~w_any;
        end
    end

    // A clear coinciding with an illegal accept still records that one error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (err_clr) begin
            r_err_count <= w_illegal ? ERRW'(1) : '0;
        end else if (w_illegal && (r_err_count != C_ERR_MAX)) begin
            r_err_count <= r_err_count + ERRW'(1);
        end
    end

    assign out_idx   = r_idx;
    assign out_err   = r_err;
    assign out_zero  = r_zero;
    assign err_count = r_err_count;

endmodule : onehot_encoder_pipe
`default_nettype wire

// File: tb/tb_onehot_encoder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_onehot_encoder_pipe
// Description : Self-checking bench for onehot_encoder_pipe (N=4, ERRW=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_encoder_pipe;
    import onehot_pkg::*;

    localparam int N    = 4;
    localparam int W    = 2;
    localparam int ERRW = 2;
    localparam int CMAX = (1 << ERRW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    in_vec;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_idx;
    logic            out_err;
    logic            out_zero;
    logic            err_clr;
    logic [ERRW-1:0] err_count;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference state: what the output stage should hold after each edge.
    bit m_valid;
    int m_idx;
    bit m_err;
    bit m_zero;
    int m_cnt;

    always #5 clk = ~clk;

    onehot_encoder_pipe #(
        .N    (N),
        .ERRW (ERRW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_err   (out_err),
        .out_zero  (out_zero),
        .err_clr   (err_clr),
        .err_count (err_count)
    );

    function automatic int ref_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic err_kind_e ref_kind(input logic [N-1:0] v);
        if ($countones(v) == 0) return ERR_ZERO;
        if ($countones(v) > 1)  return ERR_MULTI;
        return ERR_NONE;
    endfunction

    // Advance the reference by one clock, then settle 1 time unit past the edge.
    task automatic tick();
        bit        acc;
        err_kind_e k;
        acc = in_valid && (!m_valid || out_ready);
        k   = ref_kind(in_vec);
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_idx = 0; m_err = 0; m_zero = 0; m_cnt = 0;
        end else begin
            if (acc) begin
                m_valid = 1;
                m_idx   = ref_idx(in_vec);
                m_err   = (k != ERR_NONE);
                m_zero  = (k == ERR_ZERO);
            end else if (out_ready) begin
                m_valid = 0;
            end
            if (err_clr)                                m_cnt = (acc && k != ERR_NONE) ? 1 : 0;
            else if (acc && k != ERR_NONE && m_cnt < CMAX) m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; in_vec = '0; out_ready = 1; err_clr = 0;
        tick(); tick();
        rst = 0; #1;
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        n_vec++; if (out_idx !== 2'd0)   begin n_fail++; $display("FAIL reset_idx got=%0d want=0", out_idx); end
        n_vec++; if (out_err !== 1'b0 || out_zero !== 1'b0) begin n_fail++; $display("FAIL reset_flags got=%b%b want=00", out_err, out_zero); end
        n_vec++; if (err_count !== 2'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d want=0", err_count); end
        n_vec++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_onehot_sweep();
        out_ready = 1;
        for (int i = 0; i < N; i++) begin
            in_valid = 1; in_vec = N'(1) << i; #1;
            n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sweep_ready[%0d] got=%b want=1", i, in_ready); end
            tick();
            n_vec++; if (out_valid !== 1'b1 || out_idx !== W'(i) || out_err !== 1'b0)
                begin n_fail++; $display("FAIL sweep[%0d] got v=%b idx=%0d err=%b want v=1 idx=%0d err=0", i, out_valid, out_idx, out_err, i); end
        end
        in_valid = 0; tick();
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sweep_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_illegal();
        logic [N-1:0] vecs [3];
        int           want_idx [3];
        bit           want_zero [3];
        vecs = '{4'b0000, 4'b0110, 4'b1111};
        want_idx = '{0, 1, 0};
        want_zero = '{1, 0, 0};
        err_clr = 1; in_valid = 0; tick(); err_clr = 0;
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_vec = vecs[i];
            tick();
            n_vec++; if (out_idx !== W'(want_idx[i]) || out_err !== 1'b1 || out_zero !== want_zero[i])
                begin n_fail++; $display("FAIL illegal[%0d] got idx=%0d err=%b zero=%b want idx=%0d err=1 zero=%b",
                                         i, out_idx, out_err, out_zero, want_idx[i], want_zero[i]); end
        end
        in_valid = 0;
        n_vec++; if (err_count !== 2'd3) begin n_fail++; $display("FAIL illegal_cnt got=%0d want=3", err_count); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1; in_valid = 1; in_vec = 4'b0100;
        tick();
        out_ready = 0; in_vec = 4'b1000; #1;
        for (int c = 0; c < 3; c++) begin
            n_vec++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got=%b want=0", c, in_ready); end
            tick();
            n_vec++; if (out_valid !== 1'b1 || out_idx !== 2'd2) begin n_fail++; $display("FAIL bp_hold[%0d] got v=%b idx=%0d want v=1 idx=2", c, out_valid, out_idx); end
        end
        out_ready = 1; #1;
        n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got=%b want=1", in_ready); end
        tick();
        in_valid = 0;
        n_vec++; if (out_valid !== 1'b1 || out_idx !== 2'd3) begin n_fail++; $display("FAIL bp_new got v=%b idx=%0d want v=1 idx=3", out_valid, out_idx); end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_nodup got=%b want=0", out_valid); end
    endtask

    task automatic test_saturate();
        err_clr = 1; in_valid = 0; tick(); err_clr = 0;
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1;
            in_vec = (i % 2 == 0) ? 4'b0000 : 4'($urandom_range(0, 15) | 4'b0011);
            tick();
            n_vec++; if (err_count !== ERRW'((i < 3) ? i + 1 : 3))
                begin n_fail++; $display("FAIL sat[%0d] got=%0d want=%0d", i, err_count, (i < 3) ? i + 1 : 3); end
        end
        err_clr = 1; in_vec = 4'b1010; tick();
        n_vec++; if (err_count !== 2'd1) begin n_fail++; $display("FAIL clr_with_err got=%0d want=1", err_count); end
        in_valid = 0; tick();
        n_vec++; if (err_count !== 2'd0) begin n_fail++; $display("FAIL clr_alone got=%0d want=0", err_count); end
        err_clr = 0; tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1; in_valid = 1; in_vec = 4'b0011; tick();
        out_ready = 0; in_vec = 4'b0100; tick();
        rst = 1; tick(); rst = 0; in_valid = 0; #1;
        n_vec++; if (out_valid !== 1'b0 || out_idx !== 2'd0 || out_err !== 1'b0)
            begin n_fail++; $display("FAIL rstmid_out got v=%b idx=%0d err=%b want 0 0 0", out_valid, out_idx, out_err); end
        n_vec++; if (err_count !== 2'd0) begin n_fail++; $display("FAIL rstmid_cnt got=%0d want=0", err_count); end
        n_vec++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL rstmid_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_round_trip();
        logic [1:0] ab;
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            ab = 2'(k);
            in_valid = 1; in_vec = 4'b0001 << ab;
            tick();
            n_vec++; if (out_idx !== ab || out_err !== 1'b0)
                begin n_fail++; $display("FAIL roundtrip[%0d] got idx=%0d err=%b want idx=%0d err=0", k, out_idx, out_err, ab); end
        end
        in_valid = 0; tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 15) == 0);
            in_vec    = ($urandom_range(0, 1) == 1) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
            #1;
            n_vec++; if (in_ready !== (!m_valid || out_ready))
                begin n_fail++; $display("FAIL rnd_ready[%0d] got=%b want=%b", c, in_ready, (!m_valid || out_ready)); end
            tick();
            n_vec++; if (out_valid !== m_valid || err_count !== ERRW'(m_cnt))
                begin n_fail++; $display("FAIL rnd_state[%0d] got v=%b cnt=%0d want v=%b cnt=%0d", c, out_valid, err_count, m_valid, m_cnt); end
            if (m_valid) begin
                n_vec++; if (out_idx !== W'(m_idx) || out_err !== m_err || out_zero !== m_zero)
                    begin n_fail++; $display("FAIL rnd_data[%0d] got idx=%0d err=%b zero=%b want idx=%0d err=%b zero=%b",
                                             c, out_idx, out_err, out_zero, m_idx, m_err, m_zero); end
            end
        end
        in_valid = 0; err_clr = 0; out_ready = 1; tick();
    endtask

    initial begin
        test_reset();
        test_onehot_sweep();
        test_illegal();
        test_backpressure();
        test_saturate();
        test_reset_mid();
        test_round_trip();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_onehot_encoder_pipe
`default_nettype wire

// File: doc/onehot_encoder_pipe.md
Name: onehot_encoder_pipe

Overview:
Registered one-hot to binary encoder. It is the inverse of the team's 2-to-4 one-hot decoder: it turns an N-bit one-hot vector back into a log2(N)-bit index. It checks that the input is legal one-hot, counts violations, and passes results through a valid/ready handshake. It sits downstream of one-hot select/grant logic and feeds the binary-indexed datapath. It is also the loop-back check block for decoder round-trip tests.

Parameters:
- N, default 4: one-hot input width. Must be at least 2 and a power of two.
- W, default $clog2(N): index width. Derived; not overridden.
- ERRW, default 8: width of the saturating error counter.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: in_vec is presented.
- in_ready, output, 1: block can accept in_vec this cycle.
- in_vec, input, N: one-hot input vector.
- out_valid, output, 1: out_idx, out_err and out_zero are valid.
- out_ready, input, 1: consumer accepts the current output.
- out_idx, output, W: encoded binary index.
- out_err, output, 1: input was not exactly one-hot.
- out_zero, output, 1: input was all zeros.
- err_clr, input, 1: clear err_count.
- err_count, output, ERRW: saturating count of accepted illegal inputs.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_idx=0, out_err=0, out_zero=0, err_count=0. Reset dominates every other input, including mid-handshake; a held output is discarded.
- Output stage is a single register with two states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- in_ready = ~out_valid | out_ready. This is combinational; it allows full throughput with back-to-back transfers.
- An input is accepted when in_valid & in_ready. Latency is 1 cycle: the result is registered and out_valid=1 on the next edge.
- State transitions:
  - EMPTY to FULL on accept.
  - FULL stays FULL on (out_ready & accept): the new result is loaded.
  - FULL to EMPTY on (out_ready & ~accept).
  - FULL holds on ~out_ready.
- While FULL & ~out_ready, out_idx, out_err and out_zero are held stable.
- Encoding rules:
  - Exactly one bit i set: out_idx=i, out_err=0, out_zero=0.
  - No bits set: out_idx=0, out_err=1, out_zero=1.
  - Two or more bits set: out_idx = index of the lowest set bit (LSB priority), out_err=1, out_zero=0.
- err_count:
  - Increments by 1 on each accepted input with an illegal encoding.
  - Saturates at 2^ERRW-1; it never wraps.
  - err_clr=1 sets it to 0. If err_clr and an illegal accept occur in the same cycle, err_count=1.
  - in_vec is not examined when nothing is accepted, so no count is made then.
- in_vec is don't-care when in_valid=0; X on in_vec must not propagate into any register.
- No combinational path from in_vec to any output. The only combinational path is out_ready to in_ready.

Decomposition:
- Package onehot_pkg:
  - Default N.
  - Index-width function (clog2).
  - Status-flag encoding constants ERR_NONE, ERR_ZERO, ERR_MULTI for bench checking.
- Sub-module onehot_prio_enc: purely combinational, parameter N. Inputs: vec. Outputs: idx (lowest set bit), any, multi.
- The top level holds the output register, the EMPTY/FULL control and the error counter.

Test Plan:
1. N=4, out_ready=1, in_vec = 0001, 0010, 0100, 1000 on consecutive cycles. Required: out_idx = 0, 1, 2, 3 one cycle later each; out_err=0; in_ready held at 1 throughout.
2. in_vec=0000, then 0110, then 1111. Required:
   - 0000: out_idx=0, out_err=1, out_zero=1.
   - 0110: out_idx=1, out_err=1, out_zero=0.
   - 1111: out_idx=0, out_err=1.
   - err_count=3.
3. Backpressure: accept 0100, then hold out_ready=0 for 3 cycles while in_valid=1 with in_vec=1000. Required: in_ready=0; out_idx stays 2. When out_ready goes to 1, 1000 is accepted and out_idx=3 the next cycle; no input is lost or duplicated.
4. ERRW=2, feed 5 illegal inputs. Required: err_count = 1, 2, 3, 3, 3. Then err_clr together with an illegal accept gives err_count=1; err_clr alone gives 0.
5. rst=1 while FULL with out_ready=0. Required next cycle: out_valid=0, out_idx=0, out_err=0, err_count=0, in_ready=1.
6. Round trip: drive a,b through the 2-to-4 decoder into in_vec for all four combinations. Required: out_idx == {a,b}, out_err=0 for every case.
